data_ram_mc: RTL and testbench

Parametrised successor of the single-cycle data RAM: byte-lane-enabled word memory behind a request/ready handshake with configurable access latency.
- Sits between the MEM stage and backing storage; the MEM stage stalls on `busy` and consumes data on `ready`.
- Width, depth and latency are generic, so the same block serves the 32-bit core and wider future datapaths.

---
 rtl/data_ram_mc.sv | 182 ++++++++++++++++++
 tb/tb_data_ram_mc.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_mc.sv
// data_ram_mc
//   Byte-lane-enabled word memory behind a req/ready handshake with a
//   configurable access latency. The MEM stage stalls on busy and consumes
//   read data on the one-cycle ready pulse.
//
// Parameters
//   DATA_W  : data width in bits, multiple of 8 (NB = DATA_W/8 byte lanes)
//   ADDR_W  : byte-address width
//   DEPTH   : number of words, power of two
//   LATENCY : cycles from request acceptance to ready, 1..15
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous reset, active low
//   req    in   access request, sampled only while idle
//   we     in   1 = write, 0 = read, captured with req
//   addr   in   byte address; word index taken above the lane-offset bits
//   sel    in   byte-lane enables, sel[i] covers wdata[8i+7:8i]
//   wdata  in   write data
//   busy   out  high while an access is in flight (WAIT/DONE)
//   ready  out  one-cycle completion pulse for reads and writes
//   rdata  out  read data, valid with ready on a read
//   err    out  alignment error, valid with ready
//
// Build option
//   DATA_RAM_ALIGN_CHECK_EN : when defined, accesses with non-zero lane
//   offset bits are flagged with err, never write memory, and read as 0.
//   When undefined, offset bits are ignored and err is tied low.

module data_ram_mc #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W/8-1:0] sel,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    if (LATENCY < 1 || LATENCY > 15 || (DATA_W % 8) != 0) begin : g_param_check
        $error("data_ram_mc: LATENCY must be 1..15 and DATA_W a multiple of 8");
    end

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t             state, state_d;
    logic [3:0]         cnt, cnt_d;

    logic               we_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NB-1:0]      sel_q;
    logic [DATA_W-1:0]  wdata_q;

    logic [IDX_W-1:0]   idx_live;
    logic               acc_fire;
    logic               acc_we;
    logic [IDX_W-1:0]   acc_idx;
    logic [NB-1:0]      acc_sel;
    logic [DATA_W-1:0]  acc_wdata;
    logic [DATA_W-1:0]  rd_word;

    logic [NB-1:0][7:0] mem [DEPTH];

    // Upper address bits are ignored by design (index wraps modulo DEPTH).
    logic               unused_addr_bits;
    assign unused_addr_bits = ^addr;

    assign idx_live = IDX_W'(addr >> OFF_W);

`ifdef DATA_RAM_ALIGN_CHECK_EN
    logic mis_live, mis_q, acc_mis;

    assign mis_live = |(addr & ADDR_W'(NB - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mis_q <= 1'b0;
        else if (state == IDLE && req)
            mis_q <= mis_live;
    end

    assign acc_mis = (LATENCY == 1) ? mis_live : mis_q;
    assign err     = ready & mis_q;
`else
    logic acc_mis;

    assign acc_mis = 1'b0;
    assign err     = 1'b0;
`endif

    // State register plus request capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (state == IDLE && req) begin
                we_q    <= we;
                idx_q   <= idx_live;
                sel_q   <= sel;
                wdata_q <= wdata;
            end
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt - 4'd1;
                if (cnt == 4'd1)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        ready = (state == DONE);
    end

    // The access happens on the edge entering DONE. With LATENCY=1 that is
    // the accepting edge itself, so the live inputs are used instead of the
    // capture registers, which are only being loaded on that same edge.
    // Gating with rst keeps a write from landing while reset is held.
    assign acc_fire  = rst && ((LATENCY == 1) ? (state == IDLE && req)
                                              : (state == WAIT && cnt == 4'd1));
    assign acc_we    = (LATENCY == 1) ? we       : we_q;
    assign acc_idx   = (LATENCY == 1) ? idx_live : idx_q;
    assign acc_sel   = (LATENCY == 1) ? sel      : sel_q;
    assign acc_wdata = (LATENCY == 1) ? wdata    : wdata_q;
    assign rd_word   = mem[acc_idx];

    always_ff @(posedge clk) begin
        if (acc_fire && acc_we && !acc_mis) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (acc_sel[i])
                    mem[acc_idx][i] <= acc_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rdata <= '0;
        else if (acc_fire && !acc_we)
            rdata <= acc_mis ? '0 : rd_word;
    end

endmodule

// File: tb/tb_data_ram_mc.sv
// Testbench for data_ram_mc: three instances (LATENCY 2, 1 and 5) share the
// request bus, each with its own req. Expected completions are queued when a
// request is driven and checked when the matching instance raises ready.

module tb_data_ram_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_v;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [2:0]  bsy, rdy, er;
    logic [31:0] rd [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          lat_of  [3] = '{2, 1, 5};
    int          acc_cyc [3];
    logic [31:0] mdl     [3][1024];
    logic [31:0] last_rd [3];

    typedef struct {
        int          inst;
        int          lat;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_ram_mc #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst), .req(req_v[0]), .we(we), .addr(addr), .sel(sel),
        .wdata(wdata), .busy(bsy[0]), .ready(rdy[0]), .rdata(rd[0]), .err(er[0])
    );

    data_ram_mc #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req_v[1]), .we(we), .addr(addr), .sel(sel),
        .wdata(wdata), .busy(bsy[1]), .ready(rdy[1]), .rdata(rd[1]), .err(er[1])
    );

    data_ram_mc #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .LATENCY(5)) u_dut5 (
        .clk(clk), .rst(rst), .req(req_v[2]), .we(we), .addr(addr), .sel(sel),
        .wdata(wdata), .busy(bsy[2]), .ready(rdy[2]), .rdata(rd[2]), .err(er[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    // Completion monitor: every ready must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (rdy[i]) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_ready", 32'(rdy[i]), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("ready_inst", 32'(i), 32'(e.inst));
                    check_eq("latency", 32'(cyc - acc_cyc[i]), 32'(e.lat));
                    check_eq("rdata", rd[i], e.rd);
                    check_eq("err", 32'(er[i]), 32'(e.err));
                end
            end
        end
    end

    function automatic exp_t model_access(input int inst, input logic w,
                                          input logic [31:0] a, input logic [3:0] s,
                                          input logic [31:0] d);
        exp_t e;
        int   idx;
        logic mis;
        idx = int'((a >> 2) & 32'h3FF);
        mis = 1'b0;
`ifdef DATA_RAM_ALIGN_CHECK_EN
        mis = (a[1:0] != 2'b00);
`endif
        e.inst = inst;
        e.lat  = lat_of[inst];
        e.err  = mis;
        if (w) begin
            e.rd = last_rd[inst];
            if (!mis)
                for (int b = 0; b < 4; b++)
                    if (s[b]) mdl[inst][idx][8*b +: 8] = d[8*b +: 8];
        end else begin
            e.rd = mis ? 32'h0 : mdl[inst][idx];
            last_rd[inst] = e.rd;
        end
        return e;
    endfunction

    // One access; while it is in flight the bus is scrambled and req toggled,
    // none of which may disturb the captured access.
    task automatic access(input int inst, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d);
        int n;
        @(negedge clk); #1;
        we = w; addr = a; sel = s; wdata = d;
        req_v[inst]   = 1'b1;
        acc_cyc[inst] = cyc;
        sb.push_back(model_access(inst, w, a, s, d));
        @(negedge clk); #1;
        check_eq("accepted", 32'(bsy[inst]), 32'd1);
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            we          = 1'($urandom);
            addr        = $urandom;
            sel         = 4'($urandom);
            wdata       = $urandom;
            req_v[inst] = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            n++;
        end
        req_v[inst] = 1'b0;
        if (sb.size() != 0) begin
            check_eq("ready_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        int n, sz;
        logic gap_due;

        for (int i = 0; i < 3; i++) begin
            last_rd[i] = 32'h0;
            acc_cyc[i] = 0;
        end

        // Reset with a request already pending: nothing may be accepted.
        rst = 1'b0; req_v = 3'b001; we = 1'b1; addr = 32'h10; sel = 4'hF; wdata = 32'h12345678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check_eq("rst_busy", 32'(bsy[0]), 32'd0);
            check_eq("rst_ready", 32'(rdy[0]), 32'd0);
            check_eq("rst_rdata", rd[0], 32'h0);
            check_eq("rst_err", 32'(er[0]), 32'd0);
        end
        req_v = 3'b000;
        rst   = 1'b1;
        @(negedge clk); #1;
        check_eq("post_rst_idle", 32'(bsy[0]), 32'd0);

        // Write then read back, byte lanes, index wrap.
        access(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        access(0, 1'b0, 32'h10, 4'hF, 32'h0);
        access(0, 1'b1, 32'h10, 4'b0101, 32'h11223344);
        access(0, 1'b0, 32'h10, 4'hF, 32'h0);
        access(0, 1'b0, 32'h1010, 4'b0001, 32'h0);
        access(0, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF);
        access(0, 1'b0, 32'h10, 4'hF, 32'h0);
        access(0, 1'b1, 32'hFFFC, 4'hF, 32'h0BADF00D);
        access(0, 1'b0, 32'h0FFC, 4'hF, 32'h0);

        // Continuous req: one acceptance every LATENCY+1 = 3 cycles.
        @(negedge clk); #1;
        we = 1'b0; addr = 32'h10; sel = 4'hF; wdata = 32'h0;
        req_v[0]   = 1'b1;
        acc_cyc[0] = cyc;
        for (int k = 0; k < 3; k++) sb.push_back(model_access(0, 1'b0, 32'h10, 4'hF, 32'h0));
        n = 0; sz = 3; gap_due = 1'b0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk); #1;
            n++;
            if (gap_due) begin
                check_eq("hold_idle_gap", 32'(bsy[0]), 32'd0);
                gap_due = 1'b0;
            end
            if (sb.size() != sz) begin
                sz         = sb.size();
                acc_cyc[0] = acc_cyc[0] + 3;
                gap_due    = 1'b1;
                if (sz == 0) req_v[0] = 1'b0;
            end
        end
        req_v[0] = 1'b0;
        if (sb.size() != 0) begin
            check_eq("hold_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk); #1;

        // Latency sweep on the LATENCY=1 and LATENCY=5 instances.
        access(1, 1'b1, 32'h40, 4'hF, 32'hA5A5F00F);
        access(1, 1'b0, 32'h40, 4'hF, 32'h0);
        access(2, 1'b1, 32'h40, 4'b1100, 32'h13579BDF);
        access(2, 1'b1, 32'h40, 4'b0011, 32'h2468ACE0);
        access(2, 1'b0, 32'h40, 4'hF, 32'h0);

        // Reset during WAIT drops the pending write.
        access(0, 1'b1, 32'h20, 4'hF, 32'h00000000);
        @(negedge clk); #1;
        we = 1'b1; addr = 32'h20; sel = 4'hF; wdata = 32'hCAFEF00D; req_v[0] = 1'b1;
        @(negedge clk); #1;
        check_eq("mid_busy", 32'(bsy[0]), 32'd1);
        req_v[0] = 1'b0;
        rst      = 1'b0;
        #1;
        check_eq("mid_rst_busy", 32'(bsy[0]), 32'd0);
        check_eq("mid_rst_ready", 32'(rdy[0]), 32'd0);
        check_eq("mid_rst_rdata", rd[0], 32'h0);
        check_eq("mid_rst_err", 32'(er[0]), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
        access(0, 1'b0, 32'h20, 4'hF, 32'h0);

        // Misaligned accesses (flagged only when the alignment check is built in).
        access(0, 1'b1, 32'h22, 4'hF, 32'h5A5A1234);
        access(0, 1'b0, 32'h21, 4'hF, 32'h0);
        access(0, 1'b0, 32'h20, 4'hF, 32'h0);
        access(0, 1'b1, 32'h30, 4'hF, 32'h77665544);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
